// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: sizes, aligns, range-checks and extends RV64I accesses to Data_Memory.
// Optional `LSU_ALIGN_CHECK_EN: fault on addresses not a multiple of the access size.
module load_store_unit #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_mem_read,
  input  logic            req_mem_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            stall,
  output logic [XLEN-1:0] load_data,
  output logic            load_valid,
  output logic            fault,
  output logic [XLEN-1:0] dm_addr,
  output logic [XLEN-1:0] dm_wdata,
  output logic            dm_mem_read,
  output logic            dm_mem_write,
  input  logic [XLEN-1:0] dm_rdata
);

  localparam int unsigned NB = XLEN / 8;

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t          state;
  logic [XLEN-1:0] rmw_addr;
  logic [XLEN-1:0] rmw_data;

  logic [3:0]      nbytes;
  logic [XLEN:0]   end_addr;
  logic            is_op;
  logic            illegal;
  logic            range_err;
  logic            misalign;
  logic            bad;
  logic            accept;
  logic            go;
  logic            is_sd;
  logic [XLEN-1:0] merged_next;
  logic [XLEN-1:0] load_ext;

  assign nbytes    = 4'd1 << req_funct3[1:0];
  // One extra bit so addresses near the top of the space cannot wrap into low memory.
  assign end_addr  = {1'b0, req_addr} + (XLEN+1)'(nbytes);
  assign range_err = end_addr > (XLEN+1)'(MEM_BYTES);
  assign is_op     = req_mem_read | req_mem_write;
  assign illegal   = (req_mem_read & req_mem_write)
                   | (req_mem_read & (req_funct3 == 3'b111))
                   | (req_mem_write & req_funct3[2]);

`ifdef LSU_ALIGN_CHECK_EN
  logic [2:0] addr_mask;
  assign addr_mask = 3'(nbytes - 4'd1);
  assign misalign  = (req_addr[2:0] & addr_mask) != 3'b000;
`else
  assign misalign  = 1'b0;
`endif

  assign bad       = illegal | range_err | misalign;
  assign req_ready = (state == IDLE);
  assign stall     = req_valid & ~req_ready;
  assign accept    = req_valid & req_ready;
  assign go        = accept & is_op & ~bad;
  assign is_sd     = req_mem_write & (req_funct3[1:0] == 2'b11);

  always_comb begin
    merged_next = dm_rdata;
    for (int unsigned i = 0; i < NB; i++) begin
      if (i < 32'(nbytes))
        merged_next[8*i +: 8] = req_wdata[8*i +: 8];
    end
  end

  always_comb begin
    case (req_funct3)
      3'b000:  load_ext = {{(XLEN-8){dm_rdata[7]}},   dm_rdata[7:0]};
      3'b001:  load_ext = {{(XLEN-16){dm_rdata[15]}}, dm_rdata[15:0]};
      3'b010:  load_ext = {{(XLEN-32){dm_rdata[31]}}, dm_rdata[31:0]};
      3'b011:  load_ext = dm_rdata;
      3'b100:  load_ext = {{(XLEN-8){1'b0}},  dm_rdata[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, dm_rdata[15:0]};
      3'b110:  load_ext = {{(XLEN-32){1'b0}}, dm_rdata[31:0]};
      default: load_ext = '0;
    endcase
  end

  always_comb begin
    dm_mem_read  = 1'b0;
    dm_mem_write = 1'b0;
    dm_addr      = req_addr;
    dm_wdata     = req_wdata;
    if (state == RMW_WR) begin
      dm_mem_write = ~reset;
      dm_addr      = rmw_addr;
      dm_wdata     = rmw_data;
    end else if (go && !reset) begin
      dm_mem_read  = req_mem_read | ~is_sd;
      dm_mem_write = is_sd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      load_data  <= '0;
      load_valid <= 1'b0;
      fault      <= 1'b0;
      rmw_addr   <= '0;
      rmw_data   <= '0;
    end else begin
      load_valid <= go & req_mem_read;
      fault      <= accept & is_op & bad;
      if (go && req_mem_read)
        load_data <= load_ext;
      case (state)
        IDLE: begin
          if (go && req_mem_write && !is_sd) begin
            rmw_addr <= req_addr;
            rmw_data <= merged_next;
            state    <= RMW_WR;
          end
        end
        RMW_WR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: byte-array Data_Memory plus a byte-level reference model.
module tb_load_store_unit;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned MEM_BYTES = 256;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_mem_read = 1'b0;
  logic            req_mem_write = 1'b0;
  logic [2:0]      req_funct3 = 3'b000;
  logic [XLEN-1:0] req_addr = '0;
  logic [XLEN-1:0] req_wdata = '0;
  logic            stall;
  logic [XLEN-1:0] load_data;
  logic            load_valid;
  logic            fault;
  logic [XLEN-1:0] dm_addr;
  logic [XLEN-1:0] dm_wdata;
  logic            dm_mem_read;
  logic            dm_mem_write;
  logic [XLEN-1:0] dm_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(XLEN), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_mem_read(req_mem_read), .req_mem_write(req_mem_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .load_data(load_data),
    .load_valid(load_valid), .fault(fault), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_mem_read(dm_mem_read), .dm_mem_write(dm_mem_write), .dm_rdata(dm_rdata)
  );

  // Data_Memory: combinational 8-byte little-endian read, posedge 8-byte write; out-of-range bytes ignored.
  logic [7:0] mem     [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];

  always_comb begin
    dm_rdata = '0;
    for (int i = 0; i < 8; i++)
      if ({1'b0, dm_addr} + 65'(i) < 65'(MEM_BYTES))
        dm_rdata[8*i +: 8] = mem[8'(dm_addr + 64'(i))];
  end

  always @(posedge clk)
    if (dm_mem_write)
      for (int i = 0; i < 8; i++)
        if ({1'b0, dm_addr} + 65'(i) < 65'(MEM_BYTES))
          mem[8'(dm_addr + 64'(i))] <= dm_wdata[8*i +: 8];

  // ---------------- reference model ----------------
  bit          checking = 0;
  bit          accepted = 0;
  bit          exp_busy = 0;
  bit          exp_lv = 0;
  bit          exp_f = 0;
  logic [63:0] exp_ld = '0;
  logic [63:0] p_addr = '0;
  logic [63:0] p_wdata = '0;
  int          p_n = 0;

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_bad(input logic rd, input logic wr, input logic [2:0] f3, input logic [63:0] a);
    int n = size_of(f3);
    bit b = 0;
    if (rd && wr) b = 1;
    if (rd && f3 == 3'd7) b = 1;
    if (wr && f3[2]) b = 1;
    if ({1'b0, a} + 65'(n) > 65'(MEM_BYTES)) b = 1;
`ifdef LSU_ALIGN_CHECK_EN
    if (a % 64'(n) != 0) b = 1;
`endif
    return b;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [63:0] a, input int i);
    if ({1'b0, a} + 65'(i) < 65'(MEM_BYTES)) return ref_mem[8'(a + 64'(i))];
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    int n;
    logic [63:0] v;
    int sh;
    if (reset) begin
      exp_busy = 0; exp_lv = 0; exp_f = 0; exp_ld = '0; accepted = 0; checking = 1;
    end else begin
      exp_lv = 0; exp_f = 0; accepted = 0;
      if (exp_busy) begin
        for (int i = 0; i < p_n; i++) ref_mem[8'(p_addr + 64'(i))] = p_wdata[8*i +: 8];
        exp_busy = 0;
      end else if (req_valid) begin
        accepted = 1;
        n = size_of(req_funct3);
        if (req_mem_read || req_mem_write) begin
          if (is_bad(req_mem_read, req_mem_write, req_funct3, req_addr)) exp_f = 1;
          else if (req_mem_read) begin
            v = '0;
            for (int i = 0; i < n; i++) v = v | (64'(ref_byte(req_addr, i)) << (8*i));
            sh = 64 - 8*n;
            if (!req_funct3[2] && n < 8) v = $signed(v << sh) >>> sh;
            exp_ld = v;
            exp_lv = 1;
          end else if (n == 8) begin
            for (int i = 0; i < 8; i++) ref_mem[8'(req_addr + 64'(i))] = req_wdata[8*i +: 8];
          end else begin
            p_addr = req_addr; p_wdata = req_wdata; p_n = n; exp_busy = 1;
          end
        end
      end
    end
  end

  task automatic flag(input string name, input logic [63:0] act, input logic [63:0] exp);
    miscompares++;
    $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle compare, sampled well before the next rising edge.
  always @(negedge clk) begin
    logic        e_rd, e_wr;
    logic [63:0] e_addr, e_wd;
    #3;
    if (checking) begin
      vectors++;
      e_rd = 0; e_wr = 0; e_addr = req_addr; e_wd = req_wdata;
      if (exp_busy) begin
        e_wr = !reset; e_addr = p_addr;
        for (int i = 0; i < 8; i++)
          e_wd[8*i +: 8] = (i < p_n) ? p_wdata[8*i +: 8] : ref_byte(p_addr, i);
      end else if (!reset && req_valid && (req_mem_read || req_mem_write) &&
                   !is_bad(req_mem_read, req_mem_write, req_funct3, req_addr)) begin
        if (req_mem_write && size_of(req_funct3) == 8) e_wr = 1;
        else e_rd = 1;
      end
      if (dm_mem_read !== e_rd)          flag("dm_mem_read", 64'(dm_mem_read), 64'(e_rd));
      if (dm_mem_write !== e_wr)         flag("dm_mem_write", 64'(dm_mem_write), 64'(e_wr));
      if (!reset && dm_addr !== e_addr)  flag("dm_addr", dm_addr, e_addr);
      if (e_wr && dm_wdata !== e_wd)     flag("dm_wdata", dm_wdata, e_wd);
      if (req_ready !== !exp_busy)       flag("req_ready", 64'(req_ready), 64'(!exp_busy));
      if (stall !== (req_valid && exp_busy)) flag("stall", 64'(stall), 64'(req_valid && exp_busy));
      if (load_valid !== exp_lv)         flag("load_valid", 64'(load_valid), 64'(exp_lv));
      if (fault !== exp_f)               flag("fault", 64'(fault), 64'(exp_f));
      if (load_data !== exp_ld)          flag("load_data", load_data, exp_ld);
    end
  end

  // ---------------- stimulus ----------------
  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) flag(name, act, exp);
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd);
    int k = 0;
    req_valid = 1; req_mem_read = rd; req_mem_write = wr;
    req_funct3 = f3; req_addr = a; req_wdata = wd;
    do begin
      @(negedge clk); #1;
      k++;
    end while (!accepted && k < 6);
    if (!accepted) begin
      vectors++;
      flag("accept_timeout", 64'(k), 64'(2));
    end
    req_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    for (int i = 0; i < 32; i += 8) begin mem[i] = 8'h63; ref_mem[i] = 8'h63; end
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    reset = 0;
    lit("reset_load_data", load_data, 64'h0);
    lit("reset_load_valid", 64'(load_valid), 64'h0);
    lit("reset_fault", 64'(fault), 64'h0);
    lit("reset_req_ready", 64'(req_ready), 64'h1);

    issue(1, 0, 3'b011, 64'd0, 64'd0);
    lit("ld_0", load_data, 64'h63);
    lit("ld_0_valid", 64'(load_valid), 64'h1);
    issue(0, 1, 3'b011, 64'd8, 64'hFFEEDDCCBBAA9988);
    issue(1, 0, 3'b000, 64'd8, 64'd0);
    lit("lb_8", load_data, 64'hFFFFFFFFFFFFFF88);
    issue(1, 0, 3'b100, 64'd8, 64'd0);
    lit("lbu_8", load_data, 64'h88);
    issue(1, 0, 3'b110, 64'd12, 64'd0);
    lit("lwu_12", load_data, 64'hFFEEDDCC);
    issue(0, 1, 3'b011, 64'd16, 64'h1122334455667788);
    issue(0, 1, 3'b000, 64'd16, 64'h00000000000000AB);
    lit("sb_busy_ready", 64'(req_ready), 64'h0);
    issue(1, 0, 3'b011, 64'd16, 64'd0);
    lit("ld_16_merged", load_data, 64'h11223344556677AB);

    issue(0, 1, 3'b001, 64'd3, 64'h000000000000BEEF);
    idle(1);
`ifdef LSU_ALIGN_CHECK_EN
    lit("sh_3_mem3", 64'(mem[3]), 64'h00);
    lit("sh_3_mem4", 64'(mem[4]), 64'h00);
`else
    lit("sh_3_mem3", 64'(mem[3]), 64'hEF);
    lit("sh_3_mem4", 64'(mem[4]), 64'hBE);
`endif
    issue(1, 0, 3'b011, 64'hF9, 64'd0);
    lit("ld_F9_fault", 64'(fault), 64'h1);
    lit("ld_F9_valid", 64'(load_valid), 64'h0);
    issue(1, 0, 3'b111, 64'd0, 64'd0);
    lit("ld_f3_7_fault", 64'(fault), 64'h1);

    issue(0, 1, 3'b010, 64'd24, 64'h00000000DEADBEEF);
    reset = 1;
    @(negedge clk); #1;
    reset = 0;
    lit("rst_rmw_ready", 64'(req_ready), 64'h1);
    lit("rst_rmw_mem24", 64'(mem[24]), 64'h63);
    lit("rst_rmw_mem25", 64'(mem[25]), 64'h00);

    for (int it = 0; it < 700; it++) begin
      int r = $urandom_range(0, 15);
      logic rd, wr;
      logic [2:0] f3;
      logic [63:0] a;
      int n;
      rd = (r <= 6) || (r == 13);
      wr = (r >= 7 && r <= 13);
      if (rd && !wr) f3 = 3'($urandom_range(0, 7));
      else f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      n = size_of(f3);
      case ($urandom_range(0, 7))
        0:       a = {$urandom, $urandom};
        1:       a = 64'(248 + $urandom_range(0, 7));
        default: a = 64'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 1) == 1) a = a & ~64'(n - 1);
      if (r == 15) idle($urandom_range(1, 2));
      else issue(rd, wr, f3, a, {$urandom, $urandom});
    end
    idle(3);

    begin
      int diffs = 0;
      vectors++;
      for (int i = 0; i < MEM_BYTES; i++)
        if (mem[i] !== ref_mem[i]) begin
          if (diffs == 0) flag("final_mem", 64'(mem[i]), 64'(ref_mem[i]));
          diffs++;
        end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
